// File: rtl/clock_divider.sv
`timescale 1ns/1ps
// Integer clock divider with 50% duty for even and odd ratios.
// Odd ratios stretch the high phase by half a cycle with a falling-edge copy.
module clock_divider #(
  parameter int DIVISOR = 4,
  parameter int CNT_W   = $clog2(DIVISOR)
) (
  input  logic clk,
  input  logic reset,
  output logic clk_out
);

  if (DIVISOR < 2 || DIVISOR > 65536) begin : g_bad_divisor
    $error("clock_divider: DIVISOR must be in 2..65536");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] RISE = CNT_W'((DIVISOR + 1) / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pos_q, pos_d;

  // The high half starts once the phase reaches ceil(N/2) and ends at the wrap.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    pos_d = (cnt_d >= RISE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pos_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
    end
  end

  if (DIVISOR % 2 == 1) begin : g_odd
    logic neg_q;

    // Retimed copy rises/falls half a cycle late; OR keeps the early rise and the late fall.
    always_ff @(negedge clk or posedge reset) begin
      if (reset) neg_q <= 1'b0;
      else       neg_q <= pos_q;
    end

    assign clk_out = pos_q | neg_q;
  end else begin : g_even
    assign clk_out = pos_q;
  end

endmodule

// File: tb/tb_clock_divider.sv
`timescale 1ns/1ps
// Bench for clock_divider: five instances (N = 2, 3, 4, 5, 8) sharing one clock and reset.
module tb_clock_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] outs;            // {N8, N5, N4, N3, N2}
  logic       mon_en = 1'b0;
  logic       hold = 1'b0;
  int         toggles = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic       found;

  always #5 clk = ~clk;

  clock_divider #(.DIVISOR(2)) dut2 (.clk(clk), .reset(reset), .clk_out(outs[0]));
  clock_divider #(.DIVISOR(3)) dut3 (.clk(clk), .reset(reset), .clk_out(outs[1]));
  clock_divider #(.DIVISOR(4)) dut4 (.clk(clk), .reset(reset), .clk_out(outs[2]));
  clock_divider #(.DIVISOR(5)) dut5 (.clk(clk), .reset(reset), .clk_out(outs[3]));
  clock_divider #(.DIVISOR(8)) dut8 (.clk(clk), .reset(reset), .clk_out(outs[4]));

  for (genvar g = 0; g < 5; g++) begin : mon
    localparam int N = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 4 : (g == 3) ? 5 : 8;
    time last_rise = 0;
    bit  armed = 1'b0;
    int  n_rise = 0;
    int  per_err = 0;
    int  high_err = 0;

    always @(posedge outs[g]) begin
      if (mon_en && armed) begin
        n_rise++;
        if ($time - last_rise != 10 * N) per_err++;
      end
      armed = mon_en;
      last_rise = $time;
    end

    always @(negedge outs[g]) begin
      if (mon_en && armed && ($time - last_rise != 5 * N)) high_err++;
    end
  end

  always @(outs) if (hold) toggles++;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_min(input string tag, input int obs, input int lo);
    n_checks++;
    assert (obs >= lo) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected at least %0d", tag, obs, lo);
    end
  endtask

  // Expected {N8,N5,N4,N3,N2} at 27, 32, ... 82 ns; reset released at 16 ns,
  // so counted posedges 1..6 fall at 25, 35, ... 75 ns.
  logic [4:0] exp_tbl [12] = '{5'b00001, 5'b00001, 5'b00110, 5'b00110,
                               5'b01111, 5'b01101, 5'b11000, 5'b11000,
                               5'b11011, 5'b10011, 5'b10110, 5'b10100};

  initial begin
    reset = 1'b1;
    #3  check("reset_t3", outs, 5'b00000);
    #10 check("reset_t13", outs, 5'b00000);
    #3  reset = 1'b0;
    #11;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("startup_t%0d", 27 + 5 * i), outs, exp_tbl[i]);
      #5;
    end

    // Steady state: period N cycles and high time N/2 cycles over 100+ periods of every output.
    mon_en = 1'b1;
    #8200;
    mon_en = 1'b0;
    check_int("period_err_n2", mon[0].per_err, 0);
    check_int("period_err_n3", mon[1].per_err, 0);
    check_int("period_err_n4", mon[2].per_err, 0);
    check_int("period_err_n5", mon[3].per_err, 0);
    check_int("period_err_n8", mon[4].per_err, 0);
    check_int("high_err_n2", mon[0].high_err, 0);
    check_int("high_err_n3", mon[1].high_err, 0);
    check_int("high_err_n4", mon[2].high_err, 0);
    check_int("high_err_n5", mon[3].high_err, 0);
    check_int("high_err_n8", mon[4].high_err, 0);
    check_min("rises_n2", mon[0].n_rise, 100);
    check_min("rises_n3", mon[1].n_rise, 100);
    check_min("rises_n4", mon[2].n_rise, 100);
    check_min("rises_n5", mon[3].n_rise, 100);
    check_min("rises_n8", mon[4].n_rise, 100);

    // Short reset pulse while the N=4 output is high.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (outs[2] === 1'b1) found = 1'b1;
    end
    check("n4_high_found", {4'b0000, found}, 5'b00001);
    if (found) begin
      #2 reset = 1'b1;
      #1 check("pulse_async_clear", outs, 5'b00000);
      #1 reset = 1'b0;
      #3 check("pulse_after_p1", outs, 5'b00001);
      #10 check("pulse_after_p2", outs, 5'b00110);
    end

    // Long reset: output stays low for 20 cycles with no activity.
    @(negedge clk);
    reset = 1'b1;
    #1 hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2 check($sformatf("hold_c%0d", i), outs, 5'b00000);
    end
    hold = 1'b0;
    check_int("hold_toggles", toggles, 0);
    @(negedge clk);
    reset = 1'b0;
    #40;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
